// File: rtl/mux_write_128_of_16384.sv
// mux_write_128_of_16384
// Hash store for the hash checker: 128 slots of 128 bits, every slot visible
// at once on a flat 16384-bit bus so the checker can compare an incoming hash
// against all stored hashes in parallel. One slot is written per clock when
// write_trigger is high; the slot is chosen by a one-hot decode of index.
// An unwritten slot reads as zero, which the checker treats as "empty".

module mux_write_128_of_16384 (
  input  logic             clk,
  input  logic             rst,
  output logic [16383:0]   data_out,
  input  logic [6:0]       index,
  input  logic             write_trigger,
  input  logic [127:0]     data_in
);

  localparam int SLOTS  = 128;
  localparam int WORD_W = 128;

  // One-hot decode of the 7-bit slot index. Every index value maps to a real
  // slot, so there is no out-of-range handling.
  function automatic logic [SLOTS-1:0] onehot_decode(input logic [6:0] idx);
    logic [SLOTS-1:0] dec;
    dec      = '0;
    dec[idx] = 1'b1;
    return dec;
  endfunction

  // Per-slot write enables; all zero when the trigger is low.
  logic [SLOTS-1:0] slot_en;

  // Gate the decoded index with the level-sensitive write trigger.
  always_comb begin
    slot_en = '0;
    if (write_trigger) begin
      slot_en = onehot_decode(index);
    end
  end

  genvar g;
  generate
    for (g = 0; g < SLOTS; g++) begin : g_slot
      logic [WORD_W-1:0] slot_q;

      // Slot register: cleared asynchronously by reset, loaded when enabled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_q <= '0;
        end else if (slot_en[g]) begin
          slot_q <= data_in;
        end
      end

      // Flat view: slot g drives bits [g*128+127 : g*128], no output mux.
      assign data_out[g*WORD_W +: WORD_W] = slot_q;
    end
  endgenerate

endmodule

// File: tb/tb_mux_write_128_of_16384.sv
// Directed bench for mux_write_128_of_16384. Stimulus keeps an expected image
// of all slots, pushes that image into a queue at each check point and fires
// an event; an independent monitor pops the queue and compares data_out.

module tb_mux_write_128_of_16384;

  logic           clk;
  logic           rst;
  logic [16383:0] data_out;
  logic [6:0]     index;
  logic           write_trigger;
  logic [127:0]   data_in;

  mux_write_128_of_16384 dut (
    .clk           (clk),
    .rst           (rst),
    .data_out      (data_out),
    .index         (index),
    .write_trigger (write_trigger),
    .data_in       (data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0]   exp_slot [128];
  logic [16383:0] exp_q [$];
  string          name_q [$];
  event           chk_req;
  int             checks = 0;
  int             errors = 0;

  function automatic logic [16383:0] build_image();
    logic [16383:0] img;
    for (int s = 0; s < 128; s++) img[s*128 +: 128] = exp_slot[s];
    return img;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 128; s++) exp_slot[s] = '0;
  endtask

  task automatic check(input string nm);
    exp_q.push_back(build_image());
    name_q.push_back(nm);
    -> chk_req;
  endtask

  // Called at a negedge: present one write, advance past the posedge.
  task automatic drive_write(input logic [6:0] i, input logic [127:0] d);
    index         = i;
    data_in       = d;
    write_trigger = 1'b1;
    @(negedge clk);
    exp_slot[i] = d;
  endtask

  // Monitor: compare the DUT bus against each queued expected image.
  initial begin
    logic [16383:0] img;
    string          nm;
    int             bad;
    forever begin
      @(chk_req);
      while (exp_q.size() > 0) begin
        img = exp_q.pop_front();
        nm  = name_q.pop_front();
        checks++;
        if (data_out !== img) begin
          errors++;
          bad = -1;
          for (int s = 0; s < 128; s++) begin
            if (bad < 0 && data_out[s*128 +: 128] !== img[s*128 +: 128]) bad = s;
          end
          $display("FAIL %s: slot %0d got %h expected %h", nm, bad,
                   data_out[bad*128 +: 128], img[bad*128 +: 128]);
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    index         = '0;
    write_trigger = 1'b0;
    data_in       = '0;
    clear_model();

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check("after_release");

    // Single write to slot 0
    drive_write(7'd0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    write_trigger = 1'b0;
    check("single_write_slot0");

    // Top slot, all ones
    drive_write(7'd127, {128{1'b1}});
    write_trigger = 1'b0;
    check("top_slot_ones");

    // No trigger for 10 cycles with index/data activity
    for (int c = 0; c < 10; c++) begin
      index   = (c % 2 == 0) ? 7'd5 : 7'd0;
      data_in = 128'hDEAD + 128'(c);
      @(negedge clk);
      check("no_trigger_hold");
    end

    // Asynchronous reset pulse mid-cycle, no clock edge in between
    #2 rst = 1'b1;
    clear_model();
    #1 check("async_reset_pulse");
    #1 rst = 1'b0;
    @(negedge clk);
    check("after_async_pulse");

    // Fill all slots on consecutive cycles
    for (int i = 0; i < 128; i++) begin
      drive_write(7'(i), {96'h0, 32'(i + 1)});
      check("fill");
    end
    write_trigger = 1'b0;
    @(negedge clk);
    check("fill_complete");

    // Overwrite slot 64 only
    drive_write(7'd64, 128'hBEEF);
    write_trigger = 1'b0;
    check("overwrite_slot64");

    // Level trigger held 3 cycles
    drive_write(7'd10, 128'd1);
    drive_write(7'd11, 128'd2);
    drive_write(7'd12, 128'd3);
    write_trigger = 1'b0;
    check("level_trigger");

    // Same slot back to back: last write wins; constant hold is idempotent
    drive_write(7'd20, 128'hAAAA);
    drive_write(7'd20, 128'h5555);
    drive_write(7'd20, 128'h5555);
    write_trigger = 1'b0;
    check("same_slot_last_wins");

    // Reset asserted mid-stream with trigger high: that write is lost
    index         = 7'd40;
    data_in       = 128'h1234;
    write_trigger = 1'b1;
    #2 rst = 1'b1;
    clear_model();
    @(negedge clk);
    check("reset_mid_stream");
    write_trigger = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    check("idle_after_release");
    drive_write(7'd3, 128'h7);
    write_trigger = 1'b0;
    check("write_after_reset");
    @(negedge clk);
    check("final_hold");

    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL monitor_drain: pending %0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
